// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with per-entry saturating counters and a registered redirect request.
// Optional BTB_PERF_CNT_EN adds saturating branch/mispredict performance counters.
module branch_target_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int CNT_W   = 2
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [ADDR_W-1:0] upd_pred_target_i,
  input  logic              flush_all_i,
`ifdef BTB_PERF_CNT_EN
  output logic [31:0]       perf_branches_o,
  output logic [31:0]       perf_mispred_o,
`endif
  output logic              mispredict_o,
  output logic [ADDR_W-1:0] redirect_pc_o
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];

  logic [IDX_W-1:0]  l_idx, u_idx;
  logic [TAG_W-1:0]  l_tag, u_tag;
  logic              u_hit;
  logic              mispredict_d;

  // Lookup reads the pre-edge array, so a same-cycle update is seen one cycle later.
  assign l_idx         = lookup_pc_i[IDX_W+1:2];
  assign l_tag         = lookup_pc_i[ADDR_W-1:IDX_W+2];
  assign pred_hit_o    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign pred_taken_o  = pred_hit_o && cnt_q[l_idx][CNT_W-1];
  assign pred_target_o = pred_taken_o ? target_q[l_idx] : lookup_pc_i + ADDR_W'(4);

  assign u_idx = upd_pc_i[IDX_W+1:2];
  assign u_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign mispredict_d = upd_valid_i &&
                        ((upd_taken_i != upd_pred_taken_i) ||
                         (upd_taken_i && (upd_target_i != upd_pred_target_i)));

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else if (flush_all_i) begin
      // Flush wins over a simultaneous update; only valid bits matter afterwards.
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (upd_valid_i) begin
      if (u_hit) begin
        if (upd_taken_i) begin
          target_q[u_idx] <= upd_target_i;
          if (cnt_q[u_idx] != CNT_MAX) cnt_q[u_idx] <= cnt_q[u_idx] + CNT_W'(1);
        end else if (cnt_q[u_idx] != '0) begin
          cnt_q[u_idx] <= cnt_q[u_idx] - CNT_W'(1);
        end
      end else if (upd_taken_i) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target_i;
        cnt_q[u_idx]    <= CNT_WEAK;
      end
    end
  end

  // Redirect register evaluates regardless of flush.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_o  <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      mispredict_o <= mispredict_d;
      if (upd_valid_i)
        redirect_pc_o <= upd_taken_i ? upd_target_i : upd_pc_i + ADDR_W'(4);
    end
  end

`ifdef BTB_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches_o <= '0;
      perf_mispred_o  <= '0;
    end else begin
      if (upd_valid_i && (perf_branches_o != 32'hFFFF_FFFF))
        perf_branches_o <= perf_branches_o + 32'd1;
      if (mispredict_d && (perf_mispred_o != 32'hFFFF_FFFF))
        perf_mispred_o <= perf_mispred_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Randomised bench for branch_target_predictor against a behavioural BTB model.
// Define BTB_PERF_CNT_EN for both files to also check the performance counters.
module tb_branch_target_predictor;
  localparam int ADDR_W  = 32;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 2;

  logic              clk_i = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] lookup_pc_i = '0;
  logic              pred_hit_o, pred_taken_o;
  logic [ADDR_W-1:0] pred_target_o;
  logic              upd_valid_i = 1'b0;
  logic [ADDR_W-1:0] upd_pc_i = '0;
  logic              upd_taken_i = 1'b0;
  logic [ADDR_W-1:0] upd_target_i = '0;
  logic              upd_pred_taken_i = 1'b0;
  logic [ADDR_W-1:0] upd_pred_target_i = '0;
  logic              flush_all_i = 1'b0;
  logic              mispredict_o;
  logic [ADDR_W-1:0] redirect_pc_o;
`ifdef BTB_PERF_CNT_EN
  logic [31:0]       perf_branches_o, perf_mispred_o;
`endif

  branch_target_predictor #(
    .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i            (clk_i),
    .rst_n            (rst_n),
    .lookup_pc_i      (lookup_pc_i),
    .pred_hit_o       (pred_hit_o),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .upd_valid_i      (upd_valid_i),
    .upd_pc_i         (upd_pc_i),
    .upd_taken_i      (upd_taken_i),
    .upd_target_i     (upd_target_i),
    .upd_pred_taken_i (upd_pred_taken_i),
    .upd_pred_target_i(upd_pred_target_i),
    .flush_all_i      (flush_all_i),
`ifdef BTB_PERF_CNT_EN
    .perf_branches_o  (perf_branches_o),
    .perf_mispred_o   (perf_mispred_o),
`endif
    .mispredict_o     (mispredict_o),
    .redirect_pc_o    (redirect_pc_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // behavioural model: plain arrays, counters as integers
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int unsigned m_cnt   [ENTRIES];
  bit          m_mispred;
  logic [31:0] m_redirect;
  int unsigned m_branches, m_mispreds;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_cnt[idx_of(pc)] >= (1 << (CNT_W - 1)));
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    return m_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_cnt[i] = 0; m_tag[i] = 0; m_tgt[i] = '0;
    end
    m_mispred = 0; m_redirect = '0; m_branches = 0; m_mispreds = 0;
  endtask

  task automatic model_edge();
    int unsigned i;
    bit mp;
    mp = upd_valid_i && ((upd_taken_i != upd_pred_taken_i) ||
                         (upd_taken_i && upd_target_i != upd_pred_target_i));
    i = idx_of(upd_pc_i);
    if (flush_all_i) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
    end else if (upd_valid_i) begin
      if (m_hit(upd_pc_i)) begin
        if (upd_taken_i) begin
          m_tgt[i] = upd_target_i;
          if (m_cnt[i] < (1 << CNT_W) - 1) m_cnt[i]++;
        end else if (m_cnt[i] > 0) m_cnt[i]--;
      end else if (upd_taken_i) begin
        m_valid[i] = 1; m_tag[i] = tag_of(upd_pc_i);
        m_tgt[i] = upd_target_i; m_cnt[i] = 1 << (CNT_W - 1);
      end
    end
    m_mispred = mp;
    if (upd_valid_i) begin
      m_redirect = upd_taken_i ? upd_target_i : upd_pc_i + 32'd4;
      m_branches++;
    end
    if (mp) m_mispreds++;
  endtask

  // driver: apply one cycle of stimulus, check lookup before the edge and the redirect after
  task automatic step(input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                      input bit ut, input logic [31:0] utgt, input bit upt,
                      input logic [31:0] uptgt, input bit fl);
    lookup_pc_i = lpc; upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut;
    upd_target_i = utgt; upd_pred_taken_i = upt; upd_pred_target_i = uptgt;
    flush_all_i = fl;
    #1;
    check_eq("pred_hit", 32'(pred_hit_o), 32'(m_hit(lpc)));
    check_eq("pred_taken", 32'(pred_taken_o), 32'(m_taken(lpc)));
    check_eq("pred_target", pred_target_o, m_target(lpc));
    @(posedge clk_i);
    model_edge();
    #1;
    check_eq("mispredict", 32'(mispredict_o), 32'(m_mispred));
    check_eq("redirect_pc", redirect_pc_o, m_redirect);
    upd_valid_i = 1'b0; flush_all_i = 1'b0;
  endtask

  task automatic idle(input logic [31:0] lpc);
    step(lpc, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  logic [31:0] pool [8];

  initial begin
    pool[0] = 32'h0000_0040; pool[1] = 32'h0000_0080; pool[2] = 32'h0000_0044;
    pool[3] = 32'h1000_0040; pool[4] = 32'hFFFF_FFFC; pool[5] = 32'h0000_0ABC;
    pool[6] = 32'h0000_1048; pool[7] = 32'h8000_007C;
    model_reset();
    repeat (3) @(posedge clk_i);
    #2;
    lookup_pc_i = 32'h40;
    #1;
    check_eq("reset_hit", 32'(pred_hit_o), 32'h0);
    check_eq("reset_taken", 32'(pred_taken_o), 32'h0);
    check_eq("reset_target", pred_target_o, 32'h44);
    check_eq("reset_mispredict", 32'(mispredict_o), 32'h0);
    check_eq("reset_redirect", redirect_pc_o, 32'h0);
    @(negedge clk_i) rst_n = 1'b1;
    @(posedge clk_i); #1;

    // allocate 0x40 -> 0x100 with a not-taken prediction
    step(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0);
    check_eq("first_redirect", redirect_pc_o, 32'h100);
    idle(32'h40);
    check_eq("pulse_clears", 32'(mispredict_o), 32'h0);
    check_eq("hit_target", pred_target_o, 32'h100);
    // drive counter down and past zero
    repeat (3) step(32'h40, 1, 32'h40, 0, 32'h0, 0, 32'h44, 0);
    idle(32'h40);
    step(32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h100, 0);
    check_eq("nt_redirect", redirect_pc_o, 32'h44);
    // tag conflict on index 0
    step(32'h0, 1, 32'h40, 1, 32'h200, 1, 32'h200, 0);
    step(32'h40, 1, 32'h80, 1, 32'h300, 0, 32'h84, 0);
    idle(32'h40);
    idle(32'h80);
    // same-cycle lookup/update, then flush with a dropped update
    step(32'h80, 1, 32'h80, 1, 32'h340, 1, 32'h300, 0);
    idle(32'h80);
    step(32'h80, 1, 32'h100, 1, 32'h500, 0, 32'h104, 1);
    idle(32'h80);
    idle(32'h100);
    // wrap at the top address
    idle(32'hFFFF_FFFC);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] lpc, upc, utgt, uptgt;
      bit ut, upt, uv, fl;
      lpc  = pool[$urandom_range(0, 7)];
      upc  = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC) : pool[$urandom_range(0, 7)];
      uv   = ($urandom_range(0, 3) != 0);
      ut   = $urandom_range(0, 1);
      utgt = 32'h0000_2000 + (32'($urandom_range(0, 3)) << 4);
      if ($urandom_range(0, 9) < 7) begin
        upt = m_taken(upc); uptgt = m_target(upc);
      end else begin
        upt = $urandom_range(0, 1); uptgt = utgt;
      end
      fl = ($urandom_range(0, 39) == 0);
      step(lpc, uv, upc, ut, utgt, upt, uptgt, fl);
    end

`ifdef BTB_PERF_CNT_EN
    check_eq("perf_branches", perf_branches_o, m_branches);
    check_eq("perf_mispred", perf_mispred_o, m_mispreds);
`endif

    // asynchronous reset with a mispredict pending
    step(32'h40, 1, 32'h40, 1, 32'h700, 0, 32'h44, 0);
    check_eq("pre_reset_mispredict", 32'(mispredict_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    lookup_pc_i = 32'h40;
    #0;
    check_eq("async_mispredict", 32'(mispredict_o), 32'h0);
    check_eq("async_redirect", redirect_pc_o, 32'h0);
    check_eq("async_hit", 32'(pred_hit_o), 32'h0);
`ifdef BTB_PERF_CNT_EN
    check_eq("async_perf_branches", perf_branches_o, 32'h0);
    check_eq("async_perf_mispred", perf_mispred_o, 32'h0);
`endif
    @(negedge clk_i) rst_n = 1'b1;
    @(posedge clk_i); #1;
    // five updates, two mispredicted
    step(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0);
    step(32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 0);
    step(32'h40, 1, 32'h80, 0, 32'h0, 0, 32'h84, 0);
    step(32'h40, 1, 32'h40, 1, 32'h180, 1, 32'h100, 0);
    step(32'h40, 1, 32'h40, 1, 32'h180, 1, 32'h180, 0);
`ifdef BTB_PERF_CNT_EN
    check_eq("perf5_branches", perf_branches_o, 32'd5);
    check_eq("perf5_mispred", perf_mispred_o, 32'd2);
`endif
    idle(32'h40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
